string_unpack: RTL and testbench

- Consumer end of the candidate-string format produced by the string generator.
- Accepts one 512-bit candidate block, typically the block whose MD5 digest matched the target.
- Validates its length field and streams the candidate characters out one byte per handshake, oldest character first, toward the processor interface.
- Sits between the hash-compare stage and the processor readout logic.

---
 rtl/string_unpack.sv | 147 ++++++++++++++
 tb/tb_string_unpack.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_unpack.sv
// string_unpack: accepts one 512-bit candidate block, validates its bit-length field
// and streams the characters out oldest first, one byte per valid/ready handshake.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   restart     : synchronous abort, drops the string in flight
//   in_block    : [511:448] bit length, characters right-aligned in [447:0]
//   in_valid    : in_block valid
//   in_ready    : block can be accepted this cycle (combinational, state==IDLE)
//   out_char    : current character
//   out_valid   : out_char valid
//   out_ready   : downstream accepts out_char
//   out_last    : out_char is the final character
//   out_len     : character count of the current string
//   err_len     : one-cycle pulse, block rejected because of its length field
module string_unpack #(
    parameter int MAX_CHARS = 56
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         restart,
    input  logic [511:0] in_block,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_char,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [5:0]   out_len,
    output logic         err_len
);

    localparam int DW = 8 * MAX_CHARS;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [5:0]      idx_q, idx_d;
    logic [5:0]      len_q, len_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            err_q, err_d;

    logic [60:0]     nbytes;
    logic [5:0]      nb6;
    logic [5:0]      gap;
    logic [8:0]      sh;
    logic            len_bad;
    logic [DW-1:0]   aligned;

    // The whole 61-bit byte count takes part in the range check,
    // so a large value never wraps into an acceptable length.
    assign nbytes  = in_block[511:451];
    assign len_bad = (in_block[450:448] != 3'd0)
                   || (nbytes == 61'd0)
                   || (nbytes > 61'(MAX_CHARS));
    assign nb6     = in_block[456:451];

    // Left-align the string so character 0 always sits in the top byte;
    // each accepted character then just shifts the register by one byte.
    assign gap     = 6'(MAX_CHARS) - nb6;
    assign sh      = {gap, 3'b000};
    assign aligned = in_block[DW-1:0] << sh;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        len_d   = len_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SEND;
                        data_d  = aligned;
                        len_d   = nb6;
                        idx_d   = 6'd0;
                        valid_d = 1'b1;
                        last_d  = (nb6 == 6'd1);
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        data_d = data_q << 8;
                        idx_d  = idx_q + 6'd1;
                        last_d = (idx_q + 6'd2 == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            state_d = IDLE;
            data_d  = '0;
            idx_d   = 6'd0;
            len_d   = 6'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= 6'd0;
            len_q   <= 6'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_char  = data_q[DW-1 -: 8];
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_len   = len_q;
    assign err_len   = err_q;

endmodule

// File: tb/tb_string_unpack.sv
// tb_string_unpack: table-driven vectors plus hand-written corner sequences,
// characters checked against a scoreboard queue filled when blocks are driven.
module tb_string_unpack;

    logic         clk;
    logic         rst_n;
    logic         restart;
    logic [511:0] in_block;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_char;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [5:0]   out_len;
    logic         err_len;

    string_unpack #(.MAX_CHARS(56)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .in_block  (in_block),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_len   (out_len),
        .err_len   (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        logic       last;
        logic [5:0] len;
        bit         gapchk;
    } exp_t;

    typedef struct {
        logic [63:0] lenbits;
        int          n;
        logic [7:0]  base;
        bit          bad;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b1;
    bit   stall = 1'b0;
    logic [7:0] stall_char;
    logic stall_last;
    int   idle_cnt = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mk(logic [63:0] lb, int n, logic [7:0] base);
        logic [511:0] b;
        b = '0;
        b[511:448] = lb;
        for (int i = 0; i < n; i++) b[8*(n-1-i) +: 8] = base + 8'(i);
        return b;
    endfunction

    task automatic push_exp(int n, logic [7:0] base, bit gap);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ch     = base + 8'(i);
            e.last   = (i == n - 1);
            e.len    = 6'(n);
            e.gapchk = gap && (i == 0);
            q.push_back(e);
        end
    endtask

    // Drive a block and return 2ns after the edge that accepted it.
    task automatic send_block(logic [511:0] blk, int n, logic [7:0] base,
                              bit push, bit gap, bit hold);
        int k;
        @(posedge clk);
        #2;
        in_block = blk;
        in_valid = 1'b1;
        if (push) push_exp(n, base, gap);
        k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 200) begin
                $display("FAIL accept_timeout: in_ready stayed %0b want 1", in_ready);
                bad++;
                total++;
                break;
            end
        end
        @(posedge clk);
        #2;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain(int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: left=%0d want 0", q.size());
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!mon_en || !rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_char", 64'(out_char), 64'(stall_char));
                chk("hold_last", 64'(out_last), 64'(stall_last));
            end
            if (!out_valid) idle_cnt++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_char: got %0h want none", out_char);
                end else begin
                    e = q.pop_front();
                    chk("char", 64'(out_char), 64'(e.ch));
                    chk("last", 64'(out_last), 64'(e.last));
                    chk("len", 64'(out_len), 64'(e.len));
                    if (e.gapchk) chk("bubble", 64'(idle_cnt), 64'd1);
                end
                if (out_last) idle_cnt = 0;
            end
            stall      = out_valid && !out_ready;
            stall_char = out_char;
            stall_last = out_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        logic [63:0] big;
        big = 64'd1 << 60;
        vt[0] = '{64'd24,  3,  8'h61, 1'b0};
        vt[1] = '{64'd0,   0,  8'h00, 1'b1};
        vt[2] = '{64'd20,  0,  8'h00, 1'b1};
        vt[3] = '{64'd456, 0,  8'h00, 1'b1};
        vt[4] = '{64'd448, 56, 8'h01, 1'b0};
        vt[5] = '{64'd8,   1,  8'h7a, 1'b0};
        vt[6] = '{big | 64'd24, 0, 8'h00, 1'b1};

        rst_n     = 1'b0;
        restart   = 1'b0;
        in_block  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_char", 64'(out_char), 64'd0);
        chk("rst_len", 64'(out_len), 64'd0);
        chk("rst_err", 64'(err_len), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            if (vt[v].bad) begin
                send_block(mk(vt[v].lenbits, 0, 8'h00) | 512'hdead_beef,
                           0, 8'h00, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                chk("err_pulse", 64'(err_len), 64'd1);
                chk("err_novalid", 64'(out_valid), 64'd0);
                chk("err_ready", 64'(in_ready), 64'd1);
                @(negedge clk);
                chk("err_once", 64'(err_len), 64'd0);
                chk("err_novalid2", 64'(out_valid), 64'd0);
            end else begin
                send_block(mk(vt[v].lenbits, vt[v].n, vt[v].base),
                           vt[v].n, vt[v].base, 1'b1, 1'b0, 1'b0);
                @(negedge clk);
                chk("busy_ready", 64'(in_ready), 64'd0);
                chk("start_len", 64'(out_len), 64'(vt[v].n));
                chk("no_err", 64'(err_len), 64'd0);
                drain(200);
                @(negedge clk);
                chk("end_ready", 64'(in_ready), 64'd1);
                chk("end_valid", 64'(out_valid), 64'd0);
                chk("end_len", 64'(out_len), 64'(vt[v].n));
            end
        end

        // backpressure on the second character of "abc"
        out_ready = 1'b0;
        send_block(mk(64'd24, 3, 8'h61), 3, 8'h61, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_first", 64'(out_char), 64'h61);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_char", 64'(out_char), 64'h62);
            chk("bp_stall_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        drain(50);

        // back-to-back blocks with in_valid held
        send_block(mk(64'd16, 2, 8'h61), 2, 8'h61, 1'b1, 1'b0, 1'b1);
        send_block(mk(64'd24, 3, 8'h78), 3, 8'h78, 1'b1, 1'b1, 1'b0);
        drain(50);

        // synchronous restart after two characters
        mon_en = 1'b0;
        send_block(mk(64'd40, 5, 8'h41), 5, 8'h41, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        restart = 1'b1;
        @(negedge clk);
        chk("ab_char2", 64'(out_char), 64'h43);
        chk("ab_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #2;
        restart = 1'b0;
        @(negedge clk);
        chk("ab_cleared", 64'(out_valid), 64'd0);
        chk("ab_ready", 64'(in_ready), 64'd1);
        chk("ab_len", 64'(out_len), 64'd0);

        // asynchronous reset mid-string
        send_block(mk(64'd40, 5, 8'h41), 5, 8'h41, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_char", 64'(out_char), 64'd0);
        chk("ar_len", 64'(out_len), 64'd0);
        chk("ar_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // clean string after the abort
        send_block(mk(64'd24, 3, 8'h61), 3, 8'h61, 1'b1, 1'b0, 1'b0);
        drain(50);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
